// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin arbiter sharing one DMA memory port, with in-order completion tag FIFO
module dma_arbiter #(
    parameter int DEVNUM   = 4,
    parameter int TAGDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEVNUM-1:0]    req,
    input  logic [DEVNUM*22-1:0] addr,
    input  logic [DEVNUM-1:0]    rnw,
    input  logic [DEVNUM*8-1:0]  wd,
    output logic [DEVNUM-1:0]    ack,
    output logic [DEVNUM-1:0]    done,
    output logic [7:0]           rd,
    output logic                 mem_req,
    output logic [21:0]          mem_addr,
    output logic                 mem_rnw,
    output logic [7:0]           mem_wd,
    input  logic                 mem_ack,
    input  logic                 mem_end,
    input  logic [7:0]           mem_rd,
    output logic                 err
);

    localparam int IW = (DEVNUM > 1) ? $clog2(DEVNUM) : 1;
    localparam int PW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(TAGDEPTH);

    logic [IW-1:0] ptr_q, ptr_d, win;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [IW-1:0] tag_q [TAGDEPTH];
    logic          grant, pop;

    // Scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        win = ptr_q;
        for (int k = DEVNUM - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= DEVNUM) j = j - DEVNUM;
            idx = IW'(j);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        mem_req  = rst_n & (|req) & (cnt_q != FULL);
        mem_addr = addr[int'(win)*22 +: 22];
        mem_rnw  = rnw[win];
        mem_wd   = wd[int'(win)*8 +: 8];
        grant    = mem_req & mem_ack;
        pop      = rst_n & mem_end & (cnt_q != '0);
        rd       = mem_rd;
        err      = err_q;
        ack      = '0;
        done     = '0;
        if (grant) ack[win] = 1'b1;
        if (pop)   done[tag_q[rptr_q]] = 1'b1;
    end

    always_comb begin
        ptr_d  = ptr_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (mem_end & (cnt_q == '0));
        if (grant) begin
            ptr_d  = (win == IW'(DEVNUM - 1)) ? '0 : win + IW'(1);
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (grant) tag_q[wptr_q] <= win;
    end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Round-robin arbiter that shares the single DMA memory port between up to `DEVNUM` DMA clients (mp3 feeder, SD, Z80-side DMA, etc.). It forwards one client's request to the memory side per handshake and tracks granted, still-outstanding transfers in a small tag FIFO. Each client receives its own `ack` when its address is accepted, and its own `end` when its data phase completes. It sits between the per-function DMA modules and the memory-side DMA sequencer port.

## Interface

Parameters:

- `DEVNUM`, 4 — number of client ports, 2..8.
- `TAGDEPTH`, 4 — maximum outstanding (acked, not yet ended) transfers, power of two, 2..8.

Ports:

- `clk` in 1 — single clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `req` in `DEVNUM` — per-client request, held high until acked.
- `addr` in `DEVNUM*22` — client `i` address at bits `[i*22+21 : i*22]`.
- `rnw` in `DEVNUM` — per-client direction; 1 = read.
- `wd` in `DEVNUM*8` — client `i` write data at bits `[i*8+7 : i*8]`.
- `ack` out `DEVNUM` — one-hot; address of client `i` accepted this cycle.
- `done` out `DEVNUM` — one-hot; data phase of client `i` finished this cycle.
- `rd` out 8 — read data, valid with any `done` bit.
- `mem_req` out 1 — request to the memory DMA port.
- `mem_addr` out 22 — address of the selected client.
- `mem_rnw` out 1 — direction of the selected client.
- `mem_wd` out 8 — write data of the selected client.
- `mem_ack` in 1 — memory accepted `mem_addr` this cycle; meaningful only while `mem_req` = 1.
- `mem_end` in 1 — oldest outstanding transfer finished; `mem_rd` valid.
- `mem_rd` in 8 — memory read data.
- `err` out 1 — sticky protocol-error flag.

## Operation

**Registered state**
- Round-robin pointer `ptr` (0..`DEVNUM`-1).
- Tag FIFO: `TAGDEPTH` entries of client index, with read pointer, write pointer and count.
- `err`.

**Selection (combinational)**
- `win` = first index `i` with `req[i]` = 1, scanning `ptr`, `ptr+1`, … modulo `DEVNUM`.
- `mem_req` = (|`req`) & (count ≠ `TAGDEPTH`).
- `mem_addr`, `mem_rnw` and `mem_wd` come from client `win`. They are don't-care when `mem_req` = 0.
- `ack[win]` = `mem_req` & `mem_ack`; all other `ack` bits are 0.

**Grant (at the clock edge when `mem_req` & `mem_ack`)**
- Push `win` into the tag FIFO.
- `ptr` ← (`win` + 1) mod `DEVNUM`. With `DEVNUM` a non-power of two, wrap explicitly from `DEVNUM`-1 to 0.
- A client keeping `req` high after its ack stays eligible. It wins again only after every other requesting client has been served.

**Completion**
- On `mem_end` with count ≠ 0: `done[head]` = 1 combinationally, `rd` = `mem_rd`, and the head is popped at the clock edge.
- `rd` passes `mem_rd` through at all times; clients sample it only on `done`.
- Transfers complete in grant order; the memory side guarantees in-order `mem_end`.

**Boundary conditions**
- Push and pop in the same cycle: count unchanged. This is legal even when count = `TAGDEPTH`, because `mem_req` is already 0 in that case and so no push can happen.
- FIFO full: `mem_req` = 0 and no `ack` is issued; client requests stay pending.
- `mem_end` with count = 0: no `done` is asserted, `err` ← 1 (sticky), and the FIFO is unchanged.
- `mem_ack` while `mem_req` = 0: ignored, no state change.
- A client dropping `req` before its ack (abort): legal. The next candidate is selected in the same cycle.

**Reset**
- Asserting `rst_n` low (asynchronous, including mid-transfer) clears `ptr` to 0, count to 0, both FIFO pointers to 0, and `err` to 0.
- Resulting output values while in reset: `mem_req` = 0, `ack` = 0, `done` = 0.
- Any in-flight memory transfer is forgotten. A `mem_end` arriving after reset sets `err`.

## Timing

- Request to `mem_req`: 0 cycles (combinational).
- Request to `ack`: same cycle as `mem_ack`.
- `mem_end` to `done`/`rd`: 0 cycles (combinational).
- `ptr`, FIFO and `err` update on the rising `clk` edge following the event.
- Throughput: one grant per cycle when the memory acks every cycle and the FIFO is not full.
- Fairness: with all clients requesting continuously, the grant order is 0,1,…,`DEVNUM`-1,0,…
- Outputs after reset release: `mem_req` = |`req`, `err` = 0, `done` = 0.
- The first grant after reset goes to the lowest-index requester.

## Test plan

1. **Round robin**, `DEVNUM`=4: all four `req` high, `mem_ack` every cycle, `mem_end` 2 cycles after each ack → `ack` sequence 0,1,2,3,0,1; `done` follows in the same order with `rd` = `mem_rd`.
2. **Mux correctness**: only client 2 requesting, with `addr`=22'h2ABCDE, `rnw`=0, `wd`=8'h5A → `mem_addr`=22'h2ABCDE, `mem_rnw`=0, `mem_wd`=8'h5A, `ack`=4'b0100. After that ack, client 0 requests → next grant goes to 0.
3. **FIFO full**: `TAGDEPTH`=4, four acks with no `mem_end` → `mem_req` = 0 while `req` ≠ 0. One `mem_end` → `done` goes to the first granted client, and `mem_req` returns to 1 the next cycle.
4. **Simultaneous push/pop** at count=3: `mem_ack` and `mem_end` in the same cycle → count stays 3, and both `ack` and `done` assert to the correct clients.
5. **Protocol error**: `mem_end` with the FIFO empty → no `done`, `err`=1, held until reset.
6. **Mid-operation reset**: pulse `rst_n` low with 2 transfers outstanding and `ptr`=3 → `err`=0 and count=0 during and after reset. The next grant goes to the lowest-index requester, and a stale `mem_end` sets `err`.
